mux_scan_sequencer: RTL

- Drives the 3-bit select of an 8:1 single-bit channel mux in the BiDirChannels block.
- Steps through the enabled channels in ascending order. On each channel it waits a settle time, then samples the mux output for a dwell window.
- Presents one result per channel on a valid/ready handshake to the capture logic.
- Supports single-pass and continuous scanning under software control.

---
 rtl/mux_scan_if.sv | 14 +
 rtl/mux_scan_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_if.sv
// Result channel between the mux scan sequencer and the capture logic:
// one result per scanned channel, transferred on a valid/ready handshake.
interface mux_scan_if #(
  parameter int SEL_W = 3,
  parameter int CNT_W = 16
);
  logic             res_valid;
  logic             res_ready;
  logic [SEL_W-1:0] res_ch;
  logic [CNT_W-1:0] res_ones;

  modport master (output res_valid, output res_ch, output res_ones, input res_ready);
  modport slave  (input res_valid, input res_ch, input res_ones, output res_ready);
endinterface

// File: rtl/mux_scan_sequencer.sv
// Scans the enabled inputs of an 8:1 mux (settle, then dwell-sample) and emits one
// ones-count per channel. Optional result timeout/drop: define MUX_SCAN_TIMEOUT_EN.
module mux_scan_sequencer #(
  parameter int NUM_CH = 8,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [CNT_W-1:0]  settle_cycles,
  input  logic [CNT_W-1:0]  dwell_cycles,
  input  logic              mux_in,
  output logic [SEL_W-1:0]  mux_sel,
  output logic              busy,
  output logic              done,
  output logic [7:0]        pass_cnt,
`ifdef MUX_SCAN_TIMEOUT_EN
  output logic              res_drop,
`endif
  mux_scan_if.master        res
);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_DWELL, S_OUTPUT, S_NEXT} state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  ones_q, ones_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]  settle_q, settle_d;
  logic [CNT_W-1:0]  dwell_q, dwell_d;
  logic              cont_q, cont_d;
  logic              stop_pend_q, stop_pend_d;
  logic              done_q, done_d;
  logic [7:0]        pass_q, pass_d;
`ifdef MUX_SCAN_TIMEOUT_EN
  logic [7:0]        to_q, to_d;
  logic              drop_q, drop_d;
`endif

  logic [NUM_CH-1:0] above_mask;
  logic [SEL_W-1:0]  start_sel, first_sel, next_sel;

  function automatic logic [SEL_W-1:0] lowest(input logic [NUM_CH-1:0] v);
    lowest = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) lowest = SEL_W'(i);
    end
  endfunction

  // Enabled channels strictly above the current select, for the ascending search.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_above
    assign above_mask[gi] = mask_q[gi] && (SEL_W'(gi) > sel_q);
  end

  assign start_sel = lowest(ch_mask);
  assign first_sel = lowest(mask_q);
  assign next_sel  = lowest(above_mask);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    ones_d      = ones_q;
    mask_d      = mask_q;
    settle_d    = settle_q;
    dwell_d     = dwell_q;
    cont_d      = cont_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
`ifdef MUX_SCAN_TIMEOUT_EN
    to_d        = to_q;
    drop_d      = drop_q;
`endif
    case (state_q)
      S_IDLE: begin
        stop_pend_d = 1'b0;
        if (start && !stop) begin
          mask_d   = ch_mask;
          settle_d = settle_cycles;
          dwell_d  = dwell_cycles;
          cont_d   = continuous;
`ifdef MUX_SCAN_TIMEOUT_EN
          drop_d   = 1'b0;
`endif
          if (ch_mask == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_SETTLE;
            sel_d   = start_sel;
            cnt_d   = settle_cycles;
          end
        end
      end
      S_SETTLE: begin
        if (stop) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = S_DWELL;
          cnt_d   = (dwell_q == '0) ? CNT_W'(1) : dwell_q;
          ones_d  = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DWELL: begin
        if (stop) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          if (mux_in && (ones_q != '1)) ones_d = ones_q + CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            state_d = S_OUTPUT;
`ifdef MUX_SCAN_TIMEOUT_EN
            to_d    = '0;
`endif
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      S_OUTPUT: begin
        // An abort here waits for the result to leave, so it is remembered.
        if (stop) stop_pend_d = 1'b1;
        if (res.res_ready) begin
          state_d = (stop_pend_q || stop) ? S_IDLE : S_NEXT;
          done_d  = stop_pend_q || stop;
        end
`ifdef MUX_SCAN_TIMEOUT_EN
        else if (to_q == 8'hFF) begin
          drop_d  = 1'b1;
          state_d = (stop_pend_q || stop) ? S_IDLE : S_NEXT;
          done_d  = stop_pend_q || stop;
        end else begin
          to_d = to_q + 8'd1;
        end
`endif
      end
      S_NEXT: begin
        if (stop) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (|above_mask) begin
          state_d = S_SETTLE;
          sel_d   = next_sel;
          cnt_d   = settle_q;
        end else begin
          pass_d = pass_q + 8'd1;
          if (cont_q) begin
            state_d = S_SETTLE;
            sel_d   = first_sel;
            cnt_d   = settle_q;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      ones_q      <= '0;
      mask_q      <= '0;
      settle_q    <= '0;
      dwell_q     <= '0;
      cont_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= '0;
`ifdef MUX_SCAN_TIMEOUT_EN
      to_q        <= '0;
      drop_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      ones_q      <= ones_d;
      mask_q      <= mask_d;
      settle_q    <= settle_d;
      dwell_q     <= dwell_d;
      cont_q      <= cont_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
`ifdef MUX_SCAN_TIMEOUT_EN
      to_q        <= to_d;
      drop_q      <= drop_d;
`endif
    end
  end

  assign mux_sel       = sel_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign pass_cnt      = pass_q;
  assign res.res_valid = (state_q == S_OUTPUT);
  assign res.res_ch    = sel_q;
  assign res.res_ones  = ones_q;
`ifdef MUX_SCAN_TIMEOUT_EN
  assign res_drop      = drop_q;
`endif

endmodule
